// File: rtl/tx_fifo.sv
// tx_fifo: byte-wide show-ahead FIFO staging an outgoing USB payload
// between the host write port and the transmitter.
// Optional sticky overflow/underflow flags are built when the macro
// TX_FIFO_ERR_EN is defined; without it those ports and registers are absent.
module tx_fifo #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              write_enable,
  input  logic [7:0]        write_data,
  input  logic              fifo_r_enable,
  output logic [7:0]        FIFO_byte,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
`ifdef TX_FIFO_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              wr_ok;
  logic              rd_ok;

  // Status comes from count alone; acceptance uses the pre-edge flags,
  // so a write into a full FIFO is dropped even if a pop happens alongside.
  always_comb begin
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    wr_ok     = write_enable && !full;
    rd_ok     = fifo_r_enable && !empty;
    FIFO_byte = empty ? 8'h00 : mem[rptr];
  end

  // Storage array; clear leaves contents alone, they are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_ok)
      mem[wptr] <= write_data;
  end

  // Pointers and occupancy; rst and clear both flush, rst taking priority.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) rptr <= rptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef TX_FIFO_ERR_EN
  // Sticky error flags; only rst clears them, clear does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!clear) begin
      if (write_enable && full)   overflow  <= 1'b1;
      if (fifo_r_enable && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: a queue model holds the expected
// contents; bytes are pushed when a write is driven and compared on pop.
module tb_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       fifo_r_enable = 1'b0;
  logic [7:0] FIFO_byte;
  logic       empty;
  logic       full;
  logic [6:0] count;
`ifdef TX_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  tx_fifo #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .fifo_r_enable (fifo_r_enable),
    .FIFO_byte     (FIFO_byte),
    .empty         (empty),
    .full          (full),
    .count         (count)
`ifdef TX_FIFO_ERR_EN
    ,
    .overflow      (overflow),
    .underflow     (underflow)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb [$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic c, input logic we,
                      input logic [7:0] wd, input logic re);
    logic wr_ok;
    logic rd_ok;
    rst = r; clear = c; write_enable = we; write_data = wd; fifo_r_enable = re;
    if (re && !r && !c && sb.size() > 0)
      check("pop_data", 32'(FIFO_byte), 32'(sb[0]));
    @(posedge clk);
    #1;
    wr_ok = we && (sb.size() < 64);
    rd_ok = re && (sb.size() > 0);
    if (r) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (c) begin
      sb.delete();
    end else begin
      if (we && !wr_ok) m_ovf = 1'b1;
      if (re && !rd_ok) m_unf = 1'b1;
      if (rd_ok) void'(sb.pop_front());
      if (wr_ok) sb.push_back(wd);
    end
    check("count", 32'(count), 32'(sb.size()));
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("full", 32'(full), 32'(sb.size() == 64));
    check("head", 32'(FIFO_byte), (sb.size() > 0) ? 32'(sb[0]) : 32'h0);
`ifdef TX_FIFO_ERR_EN
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
`endif
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // reset and quiet idle
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) idle();

    // two bytes in, two out
    push(8'hA5);
    push(8'h3C);
    pop();
    pop();
    idle();

    // fill to full, dropped write, drain in order
    for (int i = 0; i < 64; i++) push(8'(i));
    push(8'hFF);
    for (int i = 0; i < 64; i++) pop();

    // pointer wrap with concurrent traffic
    for (int i = 0; i < 40; i++) push(8'(8'h40 + i));
    for (int i = 0; i < 40; i++) pop();
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'b0, 1'b1, 8'(8'h80 + i), sb.size() > 0);
    while (sb.size() > 0) pop();

    // full with write and read together: write dropped, count 63
    for (int i = 0; i < 64; i++) push(8'($urandom_range(255)));
    step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
    pop();

    // mid-packet reset flushes everything
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // empty with write and read together
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
    pop();
    pop();

    // clear with a concurrent write; sticky flags survive the clear
    push(8'h11);
    push(8'h12);
    push(8'h13);
    step(1'b0, 1'b0, 1'b1, 8'hCC, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 64; i++) push(8'(i));
    push(8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    pop();
    for (int i = 0; i < 10; i++) push(8'(8'hD0 + i));
    step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    idle();
    push(8'h99);
    pop();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
